// File: rtl/wb_arb2_timeout.sv
// Two-master to one-slave Wishbone arbiter with a bus watchdog; a grant takes one cycle from cyc_i and ownership holds for the whole cyc.
// Slave path is combinational from the owner; a non-owner waits, and a hung slave gets a single err pulse followed by a drain until the owner drops cyc.
module wb_arb2_timeout #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int TIMEOUT    = 255,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   m0_addr_i,
  input  logic [DW-1:0]   m0_data_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_data_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW-1:0]   m1_data_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_data_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_addr_o,
  output logic [DW-1:0]   s_data_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_data_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      gnt_o
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e        state_q;
  logic          owner_q;
  logic          last_q;
  logic [WW-1:0] wdog_q;
  logic [1:0]    gnt_q;
  logic          owner_d;

  logic [AW-1:0]   own_addr;
  logic [DW-1:0]   own_data;
  logic [DW/8-1:0] own_sel;
  logic            own_we;
  logic            own_cyc;
  logic            own_stb;

  assign own_addr = owner_q ? m1_addr_i : m0_addr_i;
  assign own_data = owner_q ? m1_data_i : m0_data_i;
  assign own_sel  = owner_q ? m1_sel_i  : m0_sel_i;
  assign own_we   = owner_q ? m1_we_i   : m0_we_i;
  assign own_cyc  = owner_q ? m1_cyc_i  : m0_cyc_i;
  assign own_stb  = owner_q ? m1_stb_i  : m0_stb_i;

  // Contention goes to m0 in fixed mode, otherwise to whoever was not served last.
  always_comb begin
    owner_d = m1_cyc_i;
    if (m0_cyc_i && m1_cyc_i) begin
      owner_d = FIXED_PRIO ? 1'b0 : ~last_q;
    end
  end

  logic active;
  logic busy;
  logic stalled;
  logic wdog_fire;
  logic ack_v;
  logic err_v;

  assign active    = (state_q != ST_IDLE) && !wb_rst_i;
  assign busy      = (state_q == ST_BUSY) && !wb_rst_i && own_cyc;
  assign stalled   = own_stb && !s_ack_i && !s_err_i;
  assign wdog_fire = busy && stalled && (wdog_q == WDOG_LAST);
  assign ack_v     = busy && s_ack_i;
  assign err_v     = (busy && s_err_i) || wdog_fire;

  assign s_addr_o = active ? own_addr : '0;
  assign s_data_o = active ? own_data : '0;
  assign s_sel_o  = active ? own_sel  : '0;
  assign s_we_o   = active && own_we;
  assign s_cyc_o  = busy;
  assign s_stb_o  = busy && own_stb;

  assign m0_ack_o  = ack_v && !owner_q;
  assign m1_ack_o  = ack_v && owner_q;
  assign m0_err_o  = err_v && !owner_q;
  assign m1_err_o  = err_v && owner_q;
  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;
  assign gnt_o     = gnt_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wdog_q  <= '0;
      gnt_q   <= 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wdog_q <= '0;
          if (m0_cyc_i || m1_cyc_i) begin
            owner_q <= owner_d;
            gnt_q   <= owner_d ? 2'b10 : 2'b01;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!own_cyc) begin
            state_q <= ST_IDLE;
            last_q  <= owner_q;
            gnt_q   <= 2'b00;
            wdog_q  <= '0;
          end else if (!stalled) begin
            wdog_q <= '0;
          end else if (wdog_q == WDOG_LAST) begin
            // Fired: the err pulse is emitted this cycle, then the slave is fenced off.
            wdog_q  <= '0;
            state_q <= ST_DRAIN;
          end else begin
            wdog_q <= wdog_q + WW'(1);
          end
        end
        ST_DRAIN: begin
          wdog_q <= '0;
          if (!own_cyc) begin
            state_q <= ST_IDLE;
            last_q  <= owner_q;
            gnt_q   <= 2'b00;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= 2'b00;
          wdog_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arb2_timeout.sv
// Randomized scoreboard bench: round-robin and fixed-priority arbiters share one stimulus stream
// and are compared every cycle against a transaction-level model of ownership and slave stalls.
module tb_wb_arb2_timeout;

  localparam int TO   = 8;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] m_addr [2];
  logic [31:0] m_wdat [2];
  logic [3:0]  m_sel  [2];
  logic        m_we   [2];
  logic        m_cyc  [2];
  logic        m_stb  [2];
  logic [31:0] s_rdat;
  logic        s_ack;
  logic        s_err;

  logic [31:0] d_rd0   [2];
  logic [31:0] d_rd1   [2];
  logic        d_ack0  [2];
  logic        d_ack1  [2];
  logic        d_err0  [2];
  logic        d_err1  [2];
  logic [31:0] d_saddr [2];
  logic [31:0] d_swdat [2];
  logic [3:0]  d_ssel  [2];
  logic        d_swe   [2];
  logic        d_scyc  [2];
  logic        d_sstb  [2];
  logic [1:0]  d_gnt   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_arb2_timeout #(
      .AW(32), .DW(32), .TIMEOUT(TO), .FIXED_PRIO(g == 1)
    ) u_dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .m0_addr_i(m_addr[0]),
      .m0_data_i(m_wdat[0]),
      .m0_sel_i (m_sel[0]),
      .m0_we_i  (m_we[0]),
      .m0_cyc_i (m_cyc[0]),
      .m0_stb_i (m_stb[0]),
      .m0_data_o(d_rd0[g]),
      .m0_ack_o (d_ack0[g]),
      .m0_err_o (d_err0[g]),
      .m1_addr_i(m_addr[1]),
      .m1_data_i(m_wdat[1]),
      .m1_sel_i (m_sel[1]),
      .m1_we_i  (m_we[1]),
      .m1_cyc_i (m_cyc[1]),
      .m1_stb_i (m_stb[1]),
      .m1_data_o(d_rd1[g]),
      .m1_ack_o (d_ack1[g]),
      .m1_err_o (d_err1[g]),
      .s_addr_o (d_saddr[g]),
      .s_data_o (d_swdat[g]),
      .s_sel_o  (d_ssel[g]),
      .s_we_o   (d_swe[g]),
      .s_cyc_o  (d_scyc[g]),
      .s_stb_o  (d_sstb[g]),
      .s_data_i (s_rdat),
      .s_ack_i  (s_ack),
      .s_err_i  (s_err),
      .gnt_o    (d_gnt[g])
    );
  end

  typedef struct packed {
    logic [1:0]  gnt;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } obs_t;

  obs_t exp_q0 [$];
  obs_t exp_q1 [$];
  int   checks   = 0;
  int   failures = 0;
  bit   armed    = 1'b0;

  // Reference: owner (-1 = nobody), fenced-off flag, last served, consecutive unanswered strobes.
  int own_m   [2];
  bit fence_m [2];
  int last_m  [2];
  int stall_m [2];
  int mrem    [2];

  function automatic obs_t expected(input int k);
    obs_t e;
    int   o;
    e     = '0;
    e.rd0 = s_rdat;
    e.rd1 = s_rdat;
    o     = own_m[k];
    if (o == 0) e.gnt = 2'b01;
    if (o == 1) e.gnt = 2'b10;
    if (!rst && o >= 0) begin
      e.addr = m_addr[o];
      e.wdat = m_wdat[o];
      e.sel  = m_sel[o];
      e.we   = m_we[o];
      if (!fence_m[k] && m_cyc[o]) begin
        e.cyc = 1'b1;
        e.stb = m_stb[o];
        if (s_ack) e.ack[o] = 1'b1;
        // The TO-th consecutive unanswered strobe is the one that gets the watchdog err.
        if (s_err || (m_stb[o] && !s_ack && stall_m[k] + 1 == TO)) e.err[o] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_step(input int k);
    int o;
    o = own_m[k];
    if (rst) begin
      own_m[k] = -1; fence_m[k] = 1'b0; last_m[k] = 1; stall_m[k] = 0;
    end else if (o < 0) begin
      stall_m[k] = 0;
      if (m_cyc[0] && m_cyc[1]) own_m[k] = (k == 1) ? 0 : 1 - last_m[k];
      else if (m_cyc[0])        own_m[k] = 0;
      else if (m_cyc[1])        own_m[k] = 1;
    end else if (!m_cyc[o]) begin
      last_m[k] = o; own_m[k] = -1; fence_m[k] = 1'b0; stall_m[k] = 0;
    end else if (!fence_m[k]) begin
      if (s_ack || s_err || !m_stb[o]) stall_m[k] = 0;
      else if (stall_m[k] + 1 == TO) begin
        fence_m[k] = 1'b1; stall_m[k] = 0;
      end else stall_m[k] = stall_m[k] + 1;
    end
  endtask

  task automatic drive(input int i);
    int ackp, stbp, maxlen, rstp;
    if (i < 1000)      begin ackp = 40; stbp = 75;  maxlen = 14; rstp = 5;  end
    else if (i < 1800) begin ackp = 6;  stbp = 97;  maxlen = 30; rstp = 5;  end
    else if (i < 2400) begin ackp = 30; stbp = 85;  maxlen = 20; rstp = 60; end
    else               begin ackp = 15; stbp = 90;  maxlen = 20; rstp = 10; end
    rst = (i < 3) || ($urandom_range(0, 999) < rstp);
    for (int k = 0; k < 2; k++) begin
      if (mrem[k] > 0) begin
        m_cyc[k] = 1'b1;
        mrem[k]  = mrem[k] - 1;
      end else begin
        m_cyc[k] = 1'b0;
        if ($urandom_range(0, 99) < 35) mrem[k] = $urandom_range(1, maxlen);
      end
      m_stb[k]  = m_cyc[k] && ($urandom_range(0, 99) < stbp);
      m_addr[k] = $urandom;
      m_wdat[k] = $urandom;
      m_sel[k]  = 4'($urandom);
      m_we[k]   = 1'($urandom);
    end
    s_ack  = $urandom_range(0, 99) < ackp;
    s_err  = $urandom_range(0, 99) < 3;
    s_rdat = $urandom;
  endtask

  function automatic obs_t actual(input int k);
    obs_t a;
    a.gnt  = d_gnt[k];
    a.cyc  = d_scyc[k];
    a.stb  = d_sstb[k];
    a.we   = d_swe[k];
    a.ack  = {d_ack1[k], d_ack0[k]};
    a.err  = {d_err1[k], d_err0[k]};
    a.sel  = d_ssel[k];
    a.addr = d_saddr[k];
    a.wdat = d_swdat[k];
    a.rd0  = d_rd0[k];
    a.rd1  = d_rd1[k];
    return a;
  endfunction

  task automatic compare(input int k, input obs_t e);
    obs_t a;
    a = actual(k);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL obs dut%0d t=%0t got gnt=%b cyc=%b stb=%b ack=%b err=%b raw=%h required gnt=%b cyc=%b stb=%b ack=%b err=%b raw=%h",
               k, $time, a.gnt, a.cyc, a.stb, a.ack, a.err, a, e.gnt, e.cyc, e.stb, e.ack, e.err, e);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        if (exp_q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL scoreboard dut0 empty at t=%0t", $time);
        end else compare(0, exp_q0.pop_front());
        if (exp_q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL scoreboard dut1 empty at t=%0t", $time);
        end else compare(1, exp_q1.pop_front());
      end
    end
  end

  initial begin
    rst    = 1'b1;
    s_rdat = '0;
    s_ack  = 1'b0;
    s_err  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_addr[k] = '0; m_wdat[k] = '0; m_sel[k] = '0;
      m_we[k] = 1'b0; m_cyc[k] = 1'b0; m_stb[k] = 1'b0;
      own_m[k] = -1; fence_m[k] = 1'b0; last_m[k] = 1; stall_m[k] = 0; mrem[k] = 0;
    end
    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      drive(i);
      exp_q0.push_back(expected(0));
      exp_q1.push_back(expected(1));
      armed = 1'b1;
    end
    @(negedge clk);
    #1;
    armed = 1'b0;
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      failures++;
      $display("FAIL leftover got=%0d/%0d required=0/0", exp_q0.size(), exp_q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
